key_tracker: RTL and testbench

Monophonic note-priority tracker between the keyboard event decoder and the glide/oscillator stage. It accepts key press/release events over a valid/ready handshake and keeps a last-note-priority stack of held keys. It drives the target frequency, the previous frequency and key_on that the glide stage consumes.

---
 rtl/synth_pkg.sv | 23 ++
 rtl/key_freq_rom.sv | 52 +++++
 rtl/key_tracker.sv | 190 +++++++++++++++++++
 tb/tb_key_tracker.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/synth_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | synth_pkg: shared types for the key tracker and key-to-pitch consumers.  |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
package synth_pkg;

  localparam int CODE_W_DEF = 8;
  localparam int FREQ_W     = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOOKUP = 2'd1,
    UPDATE = 2'd2
  } tracker_state_t;

  typedef struct packed {
    logic [CODE_W_DEF-1:0] code;
    logic [FREQ_W-1:0]     freq;
  } note_entry_t;

endpackage
`default_nettype wire

// File: rtl/key_freq_rom.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | key_freq_rom: registered key-code to pitch table, {hit, freq} one cycle  |
// | after the code is presented. Unlisted codes miss.  Revision: 1.0         |
// +--------------------------------------------------------------------------+
module key_freq_rom
  import synth_pkg::*;
#(
  parameter int CODE_W = CODE_W_DEF
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic [CODE_W-1:0] code,
  output logic              hit,
  output logic [FREQ_W-1:0] freq
);

  logic              hit_d, hit_q;
  logic [FREQ_W-1:0] freq_d, freq_q;

  // Home row, chromatic upward from 'A'
  always_comb begin
    hit_d  = 1'b1;
    freq_d = '0;
    case (code)
      CODE_W'(8'h1C): freq_d = 16'd1097;
      CODE_W'(8'h1B): freq_d = 16'd1162;
      CODE_W'(8'h23): freq_d = 16'd1231;
      CODE_W'(8'h2B): freq_d = 16'd1304;
      CODE_W'(8'h34): freq_d = 16'd1382;
      CODE_W'(8'h33): freq_d = 16'd1464;
      CODE_W'(8'h3B): freq_d = 16'd1551;
      CODE_W'(8'h42): freq_d = 16'd1643;
      default:        hit_d  = 1'b0;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      hit_q  <= 1'b0;
      freq_q <= '0;
    end else begin
      hit_q  <= hit_d;
      freq_q <= freq_d;
    end
  end

  assign hit  = hit_q;
  assign freq = freq_q;

endmodule
`default_nettype wire

// File: rtl/key_tracker.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | key_tracker: last-note-priority held-key stack driving glide target,     |
// | glide start and gate. KEY_TRACKER_LEGATO_EN disables press retrigger.    |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module key_tracker
  import synth_pkg::*;
#(
  parameter int DEPTH  = 8,
  parameter int CODE_W = 8
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              Enable,
  input  logic              ev_valid,
  output logic              ev_ready,
  input  logic [CODE_W-1:0] ev_code,
  input  logic              ev_release,
  output logic              key_on,
  output logic [FREQ_W-1:0] note_freq,
  output logic [FREQ_W-1:0] prev_freq,
  output logic [CODE_W-1:0] note_code,
  output logic              overflow
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int IDX_W = $clog2(DEPTH);

`ifdef KEY_TRACKER_LEGATO_EN
  localparam bit RETRIG_EN = 1'b0;
`else
  localparam bit RETRIG_EN = 1'b1;
`endif

  tracker_state_t    state_d, state_q;
  logic [CODE_W-1:0] code_d, code_q;
  logic              release_d, release_q;
  note_entry_t       stack_d [DEPTH];
  note_entry_t       stack_q [DEPTH];
  logic [CNT_W-1:0]  count_d, count_q;
  logic              key_on_d, key_on_q;
  logic              retrig_d, retrig_q;
  logic [FREQ_W-1:0] note_freq_d, note_freq_q;
  logic [FREQ_W-1:0] prev_freq_d, prev_freq_q;
  logic [CODE_W-1:0] note_code_d, note_code_q;
  logic              overflow_d, overflow_q;

  logic              rom_hit;
  logic [FREQ_W-1:0] rom_freq;
  logic              found, apply;
  logic [IDX_W-1:0]  found_idx, shift_lim;
  note_entry_t       new_entry;

  key_freq_rom #(.CODE_W(CODE_W)) u_rom (
    .CLK   (CLK),
    .RESET (RESET),
    .code  (code_q),
    .hit   (rom_hit),
    .freq  (rom_freq)
  );

  assign ev_ready = (state_q == IDLE) && Enable && !RESET;

  always_comb begin
    state_d     = state_q;
    code_d      = code_q;
    release_d   = release_q;
    stack_d     = stack_q;
    count_d     = count_q;
    key_on_d    = key_on_q;
    retrig_d    = 1'b0;
    note_freq_d = note_freq_q;
    prev_freq_d = prev_freq_q;
    note_code_d = note_code_q;
    overflow_d  = overflow_q;
    apply       = 1'b0;

    found     = 1'b0;
    found_idx = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (!found && (CNT_W'(i) < count_q) && (stack_q[i].code == CODE_W_DEF'(code_q))) begin
        found     = 1'b1;
        found_idx = IDX_W'(i);
      end
    end
    // An absent code shifts the whole stack, dropping the bottom slot
    shift_lim      = found ? found_idx : IDX_W'(DEPTH - 1);
    new_entry.code = CODE_W_DEF'(code_q);
    new_entry.freq = rom_freq;

    if (retrig_q) key_on_d = 1'b1;

    if (!Enable) begin
      state_d  = IDLE;
      count_d  = '0;
      key_on_d = 1'b0;
      for (int i = 0; i < DEPTH; i++) stack_d[i] = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (ev_valid && ev_ready) begin
            state_d   = LOOKUP;
            code_d    = ev_code;
            release_d = ev_release;
          end
        end
        LOOKUP: state_d = UPDATE;
        UPDATE: begin
          state_d = IDLE;
          if (!release_q && rom_hit) begin
            apply      = 1'b1;
            stack_d[0] = new_entry;
            for (int i = 1; i < DEPTH; i++) begin
              if (IDX_W'(i) <= shift_lim) stack_d[i] = stack_q[i-1];
            end
            if (!found) begin
              if (count_q == CNT_W'(DEPTH)) overflow_d = 1'b1;
              else count_d = count_q + 1'b1;
            end
          end else if (release_q && found) begin
            apply = 1'b1;
            for (int i = 0; i < DEPTH - 1; i++) begin
              if (IDX_W'(i) >= found_idx) stack_d[i] = stack_q[i+1];
            end
            stack_d[DEPTH-1] = '0;
            count_d          = count_q - 1'b1;
          end

          if (apply) begin
            if (count_d == '0) begin
              key_on_d = 1'b0;
            end else if (count_q == '0) begin
              // First note from silence starts its glide at its own pitch
              note_freq_d = stack_d[0].freq;
              prev_freq_d = stack_d[0].freq;
              note_code_d = CODE_W'(stack_d[0].code);
              key_on_d    = 1'b1;
            end else if (stack_d[0].code != stack_q[0].code) begin
              prev_freq_d = note_freq_q;
              note_freq_d = stack_d[0].freq;
              note_code_d = CODE_W'(stack_d[0].code);
            end
            if (RETRIG_EN && !release_q && (count_q != '0)) begin
              key_on_d = 1'b0;
              retrig_d = 1'b1;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q     <= IDLE;
      code_q      <= '0;
      release_q   <= 1'b0;
      stack_q     <= '{default: '0};
      count_q     <= '0;
      key_on_q    <= 1'b0;
      retrig_q    <= 1'b0;
      note_freq_q <= '0;
      prev_freq_q <= '0;
      note_code_q <= '0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      code_q      <= code_d;
      release_q   <= release_d;
      stack_q     <= stack_d;
      count_q     <= count_d;
      key_on_q    <= key_on_d;
      retrig_q    <= retrig_d;
      note_freq_q <= note_freq_d;
      prev_freq_q <= prev_freq_d;
      note_code_q <= note_code_d;
      overflow_q  <= overflow_d;
    end
  end

  assign key_on    = key_on_q;
  assign note_freq = note_freq_q;
  assign prev_freq = prev_freq_q;
  assign note_code = note_code_q;
  assign overflow  = overflow_q;

endmodule
`default_nettype wire

// File: tb/tb_key_tracker.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_key_tracker: vector table, corner sequences and random events checked |
// | against a queue-based note-priority model.  Revision: 1.0                |
// +--------------------------------------------------------------------------+
module tb_key_tracker;

  localparam int DEPTH = 4;
`ifdef KEY_TRACKER_LEGATO_EN
  localparam bit RETRIG = 1'b0;
`else
  localparam bit RETRIG = 1'b1;
`endif

  localparam logic [7:0] ROM_CODE [8] = '{8'h1C, 8'h1B, 8'h23, 8'h2B, 8'h34, 8'h33, 8'h3B, 8'h42};
  localparam int         ROM_FREQ [8] = '{1097, 1162, 1231, 1304, 1382, 1464, 1551, 1643};

  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic        Enable = 1'b1;
  logic        ev_valid = 1'b0;
  logic        ev_ready;
  logic [7:0]  ev_code = 8'h00;
  logic        ev_release = 1'b0;
  logic        key_on;
  logic [15:0] note_freq, prev_freq;
  logic [7:0]  note_code;
  logic        overflow;

  int n_checks = 0;
  int n_err    = 0;

  key_tracker #(.DEPTH(DEPTH), .CODE_W(8)) dut (
    .CLK        (CLK),
    .RESET      (RESET),
    .Enable     (Enable),
    .ev_valid   (ev_valid),
    .ev_ready   (ev_ready),
    .ev_code    (ev_code),
    .ev_release (ev_release),
    .key_on     (key_on),
    .note_freq  (note_freq),
    .prev_freq  (prev_freq),
    .note_code  (note_code),
    .overflow   (overflow)
  );

  always #5 CLK = ~CLK;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic chk_outs(input string tag, input bit kon, input int nf, input int pf,
                          input logic [7:0] nc, input bit ovf);
    chk({tag, "_key_on"},    key_on,    kon);
    chk({tag, "_note_freq"}, note_freq, nf);
    chk({tag, "_prev_freq"}, prev_freq, pf);
    chk({tag, "_note_code"}, note_code, nc);
    chk({tag, "_overflow"},  overflow,  ovf);
  endtask

  // ---------------- reference model: newest-first queue of held codes -------
  logic [7:0] mq[$];
  int         m_nf, m_pf;
  logic [7:0] m_nc;
  bit         m_kon, m_ovf;

  function automatic bit rom_ref(input logic [7:0] c, output int f);
    f = 0;
    for (int i = 0; i < 8; i++) begin
      if (ROM_CODE[i] == c) begin
        f = ROM_FREQ[i];
        return 1'b1;
      end
    end
    return 1'b0;
  endfunction

  function automatic void model_reset();
    mq.delete();
    m_nf = 0; m_pf = 0; m_nc = 8'h00; m_kon = 1'b0; m_ovf = 1'b0;
  endfunction

  // Returns whether the gate must drop for one cycle
  function automatic bit model_apply(input logic [7:0] c, input bit rel);
    int         idx = -1;
    int         f;
    int         old_n = mq.size();
    logic [7:0] old_top = (mq.size() > 0) ? mq[0] : 8'h00;
    bit         retrig = 1'b0;
    foreach (mq[i]) if (mq[i] == c) idx = i;
    if (!rel) begin
      if (!rom_ref(c, f)) return 1'b0;
      if (idx >= 0) mq.delete(idx);
      else if (mq.size() == DEPTH) begin
        void'(mq.pop_back());
        m_ovf = 1'b1;
      end
      mq.push_front(c);
      retrig = RETRIG && (old_n > 0);
    end else begin
      if (idx < 0) return 1'b0;
      mq.delete(idx);
    end
    if (mq.size() == 0) begin
      m_kon = 1'b0;
    end else begin
      void'(rom_ref(mq[0], f));
      if (old_n == 0) begin
        m_nf = f; m_pf = f; m_nc = mq[0]; m_kon = 1'b1;
      end else if (mq[0] != old_top) begin
        m_pf = m_nf; m_nf = f; m_nc = mq[0];
      end
    end
    return retrig;
  endfunction

  // ---------------- drivers (called at a falling edge) ----------------------
  task automatic accept(input logic [7:0] c, input bit rel);
    int k = 0;
    while (!ev_ready && k < 10) begin
      @(negedge CLK);
      k++;
    end
    chk("ready_wait", ev_ready, 1'b1);
    ev_valid = 1'b1; ev_code = c; ev_release = rel;
    @(posedge CLK);
    #1;
    ev_valid = 1'b0; ev_code = 8'($urandom); ev_release = 1'($urandom);
  endtask

  task automatic send(input logic [7:0] c, input bit rel, input bit pulse, input bit kon);
    accept(c, rel);
    @(negedge CLK); chk("ready_n1", ev_ready, 1'b0);
    @(negedge CLK); chk("ready_n2", ev_ready, 1'b0);
    @(negedge CLK); chk("ready_after", ev_ready, 1'b1);
    chk("key_on_n2", key_on, pulse ? 1'b0 : kon);
    @(negedge CLK); chk("key_on_n3", key_on, kon);
  endtask

  // ---------------- directed vector table -----------------------------------
  typedef struct {
    logic [7:0] code;
    bit         rel;
    bit         press_held;   // press landing on a non-empty stack
    bit         kon;
    int         nf;
    int         pf;
    logic [7:0] nc;
    bit         ovf;
  } vec_t;

  vec_t vt [18];

  initial begin
    vt[0]  = '{8'h1C, 1'b0, 1'b0, 1'b1, 1097, 1097, 8'h1C, 1'b0};
    vt[1]  = '{8'h1B, 1'b0, 1'b1, 1'b1, 1162, 1097, 8'h1B, 1'b0};
    vt[2]  = '{8'h1B, 1'b1, 1'b0, 1'b1, 1097, 1162, 8'h1C, 1'b0};
    vt[3]  = '{8'h1C, 1'b1, 1'b0, 1'b0, 1097, 1162, 8'h1C, 1'b0};
    vt[4]  = '{8'h23, 1'b0, 1'b0, 1'b1, 1231, 1231, 8'h23, 1'b0};
    vt[5]  = '{8'h23, 1'b1, 1'b0, 1'b0, 1231, 1231, 8'h23, 1'b0};
    vt[6]  = '{8'h7F, 1'b0, 1'b0, 1'b0, 1231, 1231, 8'h23, 1'b0};
    vt[7]  = '{8'h1C, 1'b1, 1'b0, 1'b0, 1231, 1231, 8'h23, 1'b0};
    vt[8]  = '{8'h1C, 1'b0, 1'b0, 1'b1, 1097, 1097, 8'h1C, 1'b0};
    vt[9]  = '{8'h1B, 1'b0, 1'b1, 1'b1, 1162, 1097, 8'h1B, 1'b0};
    vt[10] = '{8'h23, 1'b0, 1'b1, 1'b1, 1231, 1162, 8'h23, 1'b0};
    vt[11] = '{8'h2B, 1'b0, 1'b1, 1'b1, 1304, 1231, 8'h2B, 1'b0};
    vt[12] = '{8'h34, 1'b0, 1'b1, 1'b1, 1382, 1304, 8'h34, 1'b1};
    vt[13] = '{8'h1C, 1'b1, 1'b0, 1'b1, 1382, 1304, 8'h34, 1'b1};
    vt[14] = '{8'h23, 1'b0, 1'b1, 1'b1, 1231, 1382, 8'h23, 1'b1};
    vt[15] = '{8'h23, 1'b0, 1'b1, 1'b1, 1231, 1382, 8'h23, 1'b1};
    vt[16] = '{8'h2B, 1'b1, 1'b0, 1'b1, 1231, 1382, 8'h23, 1'b1};
    vt[17] = '{8'h7F, 1'b0, 1'b0, 1'b1, 1231, 1382, 8'h23, 1'b1};

    // Reset state
    repeat (3) @(negedge CLK);
    chk("rst_ready", ev_ready, 1'b0);
    chk_outs("rst", 1'b0, 0, 0, 8'h00, 1'b0);
    RESET = 1'b0;
    @(negedge CLK);

    foreach (vt[i]) begin
      send(vt[i].code, vt[i].rel, RETRIG && vt[i].press_held, vt[i].kon);
      chk_outs($sformatf("vec%0d", i), vt[i].kon, vt[i].nf, vt[i].pf, vt[i].nc, vt[i].ovf);
    end

    // Enable drops while a press of 0x1C is in LOOKUP: event lost, stack cleared
    accept(8'h1C, 1'b0);
    @(negedge CLK); Enable = 1'b0;
    @(negedge CLK);
    chk("en_drop_ready", ev_ready, 1'b0);
    chk_outs("en_drop", 1'b0, 1231, 1382, 8'h23, 1'b1);
    Enable = 1'b1;
    @(negedge CLK);
    send(8'h23, 1'b1, 1'b0, 1'b0);
    chk_outs("en_rel", 1'b0, 1231, 1382, 8'h23, 1'b1);
    send(8'h1B, 1'b0, 1'b0, 1'b1);
    chk_outs("en_first", 1'b1, 1162, 1162, 8'h1B, 1'b1);

    // Reset while an event is in flight
    accept(8'h1C, 1'b0);
    @(negedge CLK); RESET = 1'b1;
    @(negedge CLK);
    chk("midrst_ready", ev_ready, 1'b0);
    chk_outs("midrst", 1'b0, 0, 0, 8'h00, 1'b0);
    RESET = 1'b0;
    @(negedge CLK);
    model_reset();

    // Random events against the model
    for (int n = 0; n < 160; n++) begin
      logic [7:0] pool [8];
      logic [7:0] c;
      bit         rel, pulse;
      pool = '{8'h1C, 8'h1B, 8'h23, 8'h2B, 8'h34, 8'h33, 8'h7F, 8'h55};
      if ($urandom_range(0, 19) == 0) begin
        Enable = 1'b0;
        @(negedge CLK);
        Enable = 1'b1;
        mq.delete();
        m_kon = 1'b0;
        chk("rnd_en_key_on", key_on, 1'b0);
        @(negedge CLK);
      end
      c     = pool[$urandom_range(0, 7)];
      rel   = ($urandom_range(0, 9) < 4);
      pulse = model_apply(c, rel);
      send(c, rel, pulse, m_kon);
      chk_outs($sformatf("rnd%0d", n), m_kon, m_nf, m_pf, m_nc, m_ovf);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
